// File: rtl/scic_pkg.sv
// Shared definitions for the instruction fetch stage: opcode encodings,
// instruction field positions and the fetch state encoding.
package scic_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd1,
      SL  = 4'd2,
      SR  = 4'd3,
      LI  = 4'd4,
      LD  = 4'd5,
      OR  = 4'd6,
      ST  = 4'd7,
      BR  = 4'd8,
      AND = 4'd9
   } opcode_t;

   localparam int OPCODE_MSB  = 31;
   localparam int OPCODE_LSB  = 28;
   localparam int OPERAND_MSB = 15;
   localparam int OPERAND_LSB = 0;

   typedef enum logic {
      FETCH = 1'b0,
      VALID = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads one word per fetch from an external ROM and
// presents it with a valid/ready handshake. Define FETCH_PREFETCH_EN for back-to-back fetch.
module instruction_fetch
   import scic_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_chip_select,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [3:0]            inst_opcode,
   output logic [15:0]           inst_operand,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam logic [DATA_WIDTH-1:0] FIELD_MASK = DATA_WIDTH'(32'hF000_FFFF);

   fetch_state_t          state_reg, state_next;
   logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic [ADDR_WIDTH-1:0] inst_pc_reg, inst_pc_next;
   logic [3:0]            opcode_reg, opcode_next;
   logic [15:0]           operand_reg, operand_next;
   logic                  sample;

   // Bits outside the opcode/operand fields carry no meaning for this stage.
   logic unused_fields;
   assign unused_fields = ^(rom_data & ~FIELD_MASK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         pc_reg      <= '0;
         inst_pc_reg <= '0;
         opcode_reg  <= '0;
         operand_reg <= '0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         inst_pc_reg <= inst_pc_next;
         opcode_reg  <= opcode_next;
         operand_reg <= operand_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      inst_pc_next = inst_pc_reg;
      opcode_next  = opcode_reg;
      operand_next = operand_reg;
      sample       = 1'b0;

      // A redirect overrides any fetch or handshake in the same cycle.
      if (redirect_valid) begin
         pc_next    = redirect_addr;
         state_next = FETCH;
      end else begin
         case (state_reg)
            FETCH: begin
               sample     = 1'b1;
               state_next = VALID;
            end
            VALID: begin
               if (inst_ready) begin
`ifdef FETCH_PREFETCH_EN
                  sample = 1'b1;
`else
                  state_next = FETCH;
`endif
               end
            end
            default: state_next = FETCH;
         endcase
      end

      if (sample) begin
         opcode_next  = rom_data[OPCODE_MSB:OPCODE_LSB];
         operand_next = rom_data[OPERAND_MSB:OPERAND_LSB];
         inst_pc_next = pc_reg;
         pc_next      = pc_reg + ADDR_WIDTH'(1);
      end
   end

   // Reset gates the select directly so the ROM sees no access while held in reset.
   assign rom_chip_select = rst_n & sample;
   assign rom_address     = pc_reg;
   assign inst_valid      = (state_reg == VALID);
   assign inst_opcode     = opcode_reg;
   assign inst_operand    = operand_reg;
   assign inst_pc         = inst_pc_reg;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the program-memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port rom_address, output, ADDR_WIDTH bits: program-memory word address.
REQ-007 Port rom_chip_select, output, 1 bit: high when the block samples rom_data this cycle.
REQ-008 Port rom_data, input, DATA_WIDTH bits: combinational program-memory word for rom_address.
REQ-009 Port redirect_valid, input, 1 bit: branch taken this cycle.
REQ-010 Port redirect_addr, input, ADDR_WIDTH bits: branch target.
REQ-011 Port inst_valid, output, 1 bit: inst_* outputs hold a fetched instruction.
REQ-012 Port inst_ready, input, 1 bit: downstream accepts the instruction this cycle.
REQ-013 Port inst_opcode, output, 4 bits: instruction bits [31:28].
REQ-014 Port inst_operand, output, 16 bits: instruction bits [15:0].
REQ-015 Port inst_pc, output, ADDR_WIDTH bits: address the instruction was fetched from.

Function
REQ-016 The block SHALL implement states FETCH and VALID.
REQ-017 In FETCH, the block SHALL drive rom_address=pc and rom_chip_select=1, capture rom_data into the instruction register at the edge, set pc<=pc+1, and go to VALID; fetch latency is one cycle.
REQ-018 In VALID, inst_valid SHALL be 1 and inst_opcode/inst_operand/inst_pc SHALL hold stable until the handshake (inst_valid & inst_ready) completes.
REQ-019 On handshake in VALID without prefetch, the block SHALL go to FETCH.
REQ-020 pc SHALL wrap from 2^ADDR_WIDTH-1 to 0 with no other side effect.
REQ-021 redirect_valid SHALL take priority over every other event in any state: pc<=redirect_addr, inst_valid<=0 at the next edge, state<=FETCH.
REQ-022 Redirect coincident with handshake SHALL count the current instruction as consumed and fetch the next instruction from redirect_addr.
REQ-023 Unused bits [27:16] SHALL be ignored.
REQ-024 rom_chip_select SHALL be 0 whenever no sample is taken.

Reset
REQ-025 While rst_n=0, the block SHALL hold state=FETCH, pc=0, instruction register=0, inst_valid=0, rom_address=0, and rom_chip_select=0.
REQ-026 Reset asserted mid-fetch or mid-handshake SHALL discard the instruction, with no partial update.
REQ-027 After reset release, the first fetch SHALL start on the first clk edge.

Configuration
REQ-028 When FETCH_PREFETCH_EN is defined, in VALID the block SHALL drive rom_address=pc and rom_chip_select=1, and on handshake SHALL load the next word, increment pc, and remain in VALID, sustaining one instruction per cycle.
REQ-029 When FETCH_PREFETCH_EN is undefined, the block SHALL sustain at most one instruction per two cycles, with rom_chip_select=0 in VALID.

Structure
REQ-030 Shared package scic_pkg SHALL hold the opcode enum (ADD=1, SL=2, SR=3, LI=4, LD=5, OR=6, ST=7, BR=8, AND=9), the opcode and operand field bit positions, and the fetch state enum.
REQ-031 The block SHALL be flat with no sub-module; the memory is instantiated externally and connected via the rom_* ports.

Verification
REQ-032 Release reset with rom[0]=0x4000000F and inst_ready=1 -> inst_valid=1 one cycle after the first edge, with opcode=4, operand=0x000F, and inst_pc=0.
REQ-033 Hold inst_ready=0 for 3 cycles -> outputs stable and pc unchanged; on assertion of inst_ready, the next instruction comes from pc+1.
REQ-034 With inst_ready=1, run pc to 31 -> the next fetch is at address 0.
REQ-035 Assert redirect_valid with redirect_addr=3 while VALID and inst_ready=1 -> the next valid instruction has inst_pc=3, and no instruction from the old stream appears.
REQ-036 With inst_ready tied high for 10 cycles -> 10 handshakes with FETCH_PREFETCH_EN defined, 5 handshakes without.
REQ-037 Assert rst_n=0 in VALID -> inst_valid=0 immediately (asynchronously), and pc=0.
